// File: rtl/bridge_burst_gen.sv
// Multi-channel full-bridge burst generator with dead time,
// unipolar/bipolar modes and protection lockout.
module bridge_burst_gen #(
  parameter int NCH     = 2,
  parameter int PW      = 10,
  parameter int NW      = 6,
  parameter int DW      = 6,
  parameter int HOLDOFF = 100_000_000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [PW-1:0]  half_len,
  input  logic [DW-1:0]  dead_len,
  input  logic [NW-1:0]  pulse_num,
  input  logic           mode,
  input  logic [NCH-1:0] ch_en,
  input  logic [NCH-1:0] invert,
  input  logic           trig,
  input  logic           protect,
  output logic [NCH-1:0] a_h,
  output logic [NCH-1:0] a_l,
  output logic [NCH-1:0] b_h,
  output logic [NCH-1:0] b_l,
  output logic           busy,
  output logic           done,
  output logic           fault_lock
);

  localparam int CW = (PW > DW) ? PW : DW;
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLDOFF - 1);

  typedef enum logic [2:0] {IDLE, P, DA, N, DB, LOCK} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   phase_q, phase_n;
  logic [NW-1:0]   pulse_q, pulse_n;
  logic [HW-1:0]   hold_q, hold_n;
  logic [PW-1:0]   h_q;
  logic [DW-1:0]   d_q;
  logic [NW-1:0]   n_q;
  logic            mode_q;
  logic [NCH-1:0]  en_q, inv_q;
  logic            trig_prev, fin, fin_q, latch, pend;
  logic            h_end, d_end, last, edge_t;
  logic [CW-1:0]   h_last, d_last;
  logic [1:0]      base_a, base_b;
  logic [NCH-1:0]  ah_n, al_n, bh_n, bl_n;

  assign h_last = (h_q == '0) ? '0 : CW'(h_q) - CW'(1);
  assign d_last = CW'(d_q) - CW'(1);
  assign h_end  = (phase_q == h_last);
  assign d_end  = (phase_q == d_last);
  assign last   = (pulse_q == n_q - NW'(1));
  assign edge_t = trig & ~trig_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase_q   <= '0;
      pulse_q   <= '0;
      hold_q    <= '0;
      trig_prev <= 1'b1;
      fin_q     <= 1'b0;
      h_q       <= '0;
      d_q       <= '0;
      n_q       <= '0;
      mode_q    <= 1'b0;
      en_q      <= '0;
      inv_q     <= '0;
    end else begin
      state     <= state_n;
      phase_q   <= phase_n;
      pulse_q   <= pulse_n;
      hold_q    <= hold_n;
      trig_prev <= trig;
      fin_q     <= fin;
      if (latch) begin
        h_q    <= half_len;
        d_q    <= dead_len;
        n_q    <= pulse_num;
        mode_q <= mode;
        en_q   <= ch_en;
        inv_q  <= invert;
      end
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase_q + CW'(1);
    pulse_n = pulse_q;
    hold_n  = hold_q;
    fin     = 1'b0;
    latch   = 1'b0;
    pend    = 1'b0;
    unique case (state)
      IDLE: begin
        phase_n = '0;
        pulse_n = '0;
        hold_n  = '0;
        if (edge_t) begin
          latch = 1'b1;
          if (pulse_num == '0) fin = 1'b1;
          else state_n = P;
        end
      end
      P: if (h_end) begin
        phase_n = '0;
        if (d_q != '0) state_n = DA;
        else if (!mode_q) state_n = N;
        else pend = 1'b1;
      end
      DA: if (d_end) begin
        phase_n = '0;
        if (!mode_q) state_n = N;
        else pend = 1'b1;
      end
      N: if (h_end) begin
        phase_n = '0;
        if (d_q != '0) state_n = DB;
        else pend = 1'b1;
      end
      DB: if (d_end) begin
        phase_n = '0;
        pend    = 1'b1;
      end
      LOCK: begin
        phase_n = '0;
        pulse_n = '0;
        hold_n  = hold_q + HW'(1);
        if (hold_q == HLAST) begin
          hold_n = '0;
          if (!protect) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (pend) begin
      pulse_n = pulse_q + NW'(1);
      if (last) begin
        state_n = IDLE;
        fin     = 1'b1;
      end else begin
        state_n = P;
      end
    end
    // Fault wins over everything, including a completing burst.
    if (protect && state != LOCK) begin
      state_n = LOCK;
      phase_n = '0;
      pulse_n = '0;
      hold_n  = '0;
      fin     = 1'b0;
      latch   = 1'b0;
    end
  end

  always_comb begin
    base_a = 2'b01;
    base_b = 2'b01;
    ah_n   = '0;
    al_n   = '0;
    bh_n   = '0;
    bl_n   = '0;
    unique case (state)
      P: begin
        base_a = 2'b10;
        base_b = 2'b01;
      end
      N: begin
        base_a = 2'b01;
        base_b = 2'b10;
      end
      DA: begin
        base_a = 2'b00;
        base_b = mode_q ? 2'b01 : 2'b00;
      end
      DB: begin
        base_a = last ? 2'b01 : 2'b00;
        base_b = 2'b00;
      end
      default: begin
        base_a = 2'b01;
        base_b = 2'b01;
      end
    endcase
    for (int c = 0; c < NCH; c++) begin
      {ah_n[c], al_n[c]} = !en_q[c] ? 2'b01 :
                           (inv_q[c] ? base_b : base_a);
      {bh_n[c], bl_n[c]} = !en_q[c] ? 2'b01 :
                           (inv_q[c] ? base_a : base_b);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_h        <= '0;
      a_l        <= '1;
      b_h        <= '0;
      b_l        <= '1;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault_lock <= 1'b0;
    end else begin
      a_h        <= ah_n;
      a_l        <= al_n;
      b_h        <= bh_n;
      b_l        <= bl_n;
      busy       <= (state == P) || (state == DA) ||
                    (state == N) || (state == DB);
      done       <= fin_q;
      fault_lock <= (state == LOCK);
    end
  end

endmodule

// File: tb/tb_bridge_burst_gen.sv
// Directed bench for bridge_burst_gen: vector table of burst
// configurations plus hand sequences for protect, retrigger, reset.
module tb_bridge_burst_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] half_len;
  logic [5:0] dead_len;
  logic [5:0] pulse_num;
  logic       mode;
  logic [1:0] ch_en, invert;
  logic       trig, protect;
  logic [1:0] a_h, a_l, b_h, b_l;
  logic       busy, done, fault_lock;

  int nchk = 0;
  int nerr = 0;

  bridge_burst_gen #(
    .NCH(2), .PW(10), .NW(6), .DW(6), .HOLDOFF(20)
  ) dut (
    .clk(clk), .reset(reset),
    .half_len(half_len), .dead_len(dead_len),
    .pulse_num(pulse_num), .mode(mode),
    .ch_en(ch_en), .invert(invert),
    .trig(trig), .protect(protect),
    .a_h(a_h), .a_l(a_l), .b_h(b_h), .b_l(b_l),
    .busy(busy), .done(done), .fault_lock(fault_lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] h;
    logic [5:0] d;
    logic [5:0] n;
    logic       m;
    logic [1:0] en;
    logic [1:0] inv;
    int         blen;
    int         donec;
    logic [7:0] legs;
  } vec_t;

  vec_t vecs[7];

  logic [1:0] cah[0:127], cal[0:127], cbh[0:127], cbl[0:127];
  logic       cb[0:127], cd[0:127], cf[0:127];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] leg(input int k, input int c);
    return {cah[k][c], cal[k][c], cbh[k][c], cbl[k][c]};
  endfunction

  task automatic setcfg(input vec_t v);
    half_len  = v.h;
    dead_len  = v.d;
    pulse_num = v.n;
    mode      = v.m;
    ch_en     = v.en;
    invert    = v.inv;
  endtask

  // Index k holds outputs k negedges after the call (input cycle t+k).
  task automatic run(input int ncyc, input bit do_trig,
                     input int t_off, input int r_on, input int r_off,
                     input int p_on, input int p_off);
    for (int k = 0; k <= ncyc; k++) begin
      if (k > 0) begin
        @(negedge clk);
        cah[k] = a_h; cal[k] = a_l;
        cbh[k] = b_h; cbl[k] = b_l;
        cb[k] = busy; cd[k] = done; cf[k] = fault_lock;
      end
      if (k == 0 && do_trig) trig = 1'b1;
      if (k == t_off) trig = 1'b0;
      if (k == r_on) trig = 1'b1;
      if (k == r_off) trig = 1'b0;
      if (k == p_on) protect = 1'b1;
      if (k == p_off) protect = 1'b0;
    end
  endtask

  task automatic stats(input int ncyc, output int nb, output int fb,
                       output int nd, output int fd, output int nf,
                       output int bad);
    nb = 0; fb = -1; nd = 0; fd = -1; nf = 0; bad = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (cb[k]) begin
        nb++;
        if (fb < 0) fb = k;
      end
      if (cd[k]) begin
        nd++;
        if (fd < 0) fd = k;
      end
      if (cf[k]) nf++;
      for (int c = 0; c < 2; c++)
        if ((cah[k][c] & cbh[k][c]) | (cah[k][c] & cal[k][c]) |
            (cbh[k][c] & cbl[k][c]))
          bad++;
    end
  endtask

  initial begin
    int nb, fb, nd, fd, nf, bad, mis;
    int j, r;
    logic [3:0] e;
    vec_t pv;

    vecs[0] = '{10'd9, 6'd3, 6'd4, 1'b0, 2'b11, 2'b00, 96, 97, 8'b1001_1001};
    vecs[1] = '{10'd5, 6'd0, 6'd2, 1'b1, 2'b11, 2'b00, 10, 11, 8'b1001_1001};
    vecs[2] = '{10'd2, 6'd1, 6'd1, 1'b0, 2'b10, 2'b10, 6, 7, 8'b0101_0110};
    vecs[3] = '{10'd4, 6'd1, 6'd0, 1'b0, 2'b11, 2'b00, 0, 1, 8'b0101_0101};
    vecs[4] = '{10'd0, 6'd0, 6'd3, 1'b0, 2'b11, 2'b00, 6, 7, 8'b1001_1001};
    vecs[5] = '{10'd3, 6'd2, 6'd3, 1'b1, 2'b11, 2'b00, 15, 16, 8'b1001_1001};
    vecs[6] = '{10'd0, 6'd2, 6'd1, 1'b0, 2'b11, 2'b00, 6, 7, 8'b1001_1001};

    reset = 1'b1; trig = 1'b0; protect = 1'b0;
    setcfg(vecs[0]);
    repeat (3) @(negedge clk);
    chk("rst_a_h", int'(a_h), 0);
    chk("rst_a_l", int'(a_l), 3);
    chk("rst_b_h", int'(b_h), 0);
    chk("rst_b_l", int'(b_l), 3);
    chk("rst_flags", int'({busy, done, fault_lock}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      setcfg(vecs[i]);
      run(vecs[i].blen + 10, 1'b1, 1, -1, -1, -1, -1);
      stats(vecs[i].blen + 10, nb, fb, nd, fd, nf, bad);
      chk($sformatf("v%0d_busy_len", i), nb, vecs[i].blen);
      chk($sformatf("v%0d_busy_first", i), fb,
          (vecs[i].blen > 0) ? 2 : -1);
      chk($sformatf("v%0d_done_cnt", i), nd, 1);
      chk($sformatf("v%0d_done_at", i), fd, vecs[i].donec + 1);
      chk($sformatf("v%0d_legs", i),
          int'({leg(2, 0), leg(2, 1)}), int'(vecs[i].legs));
      chk($sformatf("v%0d_safety", i), bad, 0);
      repeat (2) @(negedge clk);
    end

    setcfg(vecs[0]);
    run(106, 1'b1, 1, -1, -1, -1, -1);
    mis = 0;
    for (int i = 1; i <= 97; i++) begin
      j = i - 1;
      r = j % 24;
      if (i == 97) e = 4'b0101;
      else if (r < 9) e = 4'b1001;
      else if (r < 12) e = 4'b0000;
      else if (r < 21) e = 4'b0110;
      else e = (j / 24 == 3) ? 4'b0100 : 4'b0000;
      if (leg(i + 1, 0) != e || leg(i + 1, 1) != e) mis++;
    end
    chk("bip_seq", mis, 0);
    repeat (2) @(negedge clk);

    setcfg(vecs[1]);
    run(16, 1'b1, 1, -1, -1, -1, -1);
    mis = 0;
    for (int i = 1; i <= 11; i++) begin
      e = (i <= 10) ? 4'b1001 : 4'b0101;
      if (leg(i + 1, 0) != e) mis++;
    end
    chk("uni_seq", mis, 0);
    repeat (2) @(negedge clk);

    setcfg(vecs[5]);
    run(22, 1'b1, 1, -1, -1, -1, -1);
    mis = 0;
    for (int i = 1; i <= 16; i++) begin
      r = (i - 1) % 5;
      if (i == 16) e = 4'b0101;
      else e = (r < 3) ? 4'b1001 : 4'b0001;
      if (leg(i + 1, 1) != e) mis++;
    end
    chk("uni_dead_seq", mis, 0);
    repeat (2) @(negedge clk);

    pv = '{10'd4, 6'd2, 6'd3, 1'b0, 2'b11, 2'b00, 36, 37, 8'h00};
    setcfg(pv);
    run(60, 1'b1, -1, -1, -1, 20, 24);
    stats(60, nb, fb, nd, fd, nf, bad);
    chk("prot_pre", int'(leg(21, 0)), int'(4'b0110));
    chk("prot_safe", int'({leg(22, 0), leg(22, 1)}), int'(8'b0101_0101));
    chk("prot_flag", int'(cf[22]), 1);
    chk("prot_lock_len", nf, 20);
    chk("prot_no_done", nd, 0);
    chk("prot_busy_len", nb, 20);
    chk("prot_safety", bad, 0);
    trig = 1'b0;
    repeat (2) @(negedge clk);
    pv = '{10'd1, 6'd0, 6'd1, 1'b0, 2'b11, 2'b00, 2, 3, 8'h00};
    setcfg(pv);
    run(8, 1'b1, 1, -1, -1, -1, -1);
    stats(8, nb, fb, nd, fd, nf, bad);
    chk("post_lock_busy", nb, 2);
    chk("post_lock_first", fb, 2);
    repeat (2) @(negedge clk);

    run(60, 1'b0, -1, -1, -1, 0, 24);
    stats(60, nb, fb, nd, fd, nf, bad);
    chk("lock_restart_len", nf, 40);
    chk("lock_restart_busy", nb, 0);
    repeat (2) @(negedge clk);

    pv = '{10'd3, 6'd1, 6'd2, 1'b0, 2'b11, 2'b00, 16, 17, 8'h00};
    setcfg(pv);
    run(40, 1'b1, 1, 6, 8, -1, -1);
    stats(40, nb, fb, nd, fd, nf, bad);
    chk("retrig_busy", nb, 16);
    chk("retrig_done_cnt", nd, 1);
    chk("retrig_done_at", fd, 18);
    repeat (2) @(negedge clk);

    setcfg(vecs[0]);
    run(10, 1'b1, -1, -1, -1, -1, -1);
    chk("mid_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_h", int'({a_h, b_h}), 0);
    chk("mid_rst_l", int'({a_l, b_l}), 15);
    chk("mid_rst_flags", int'({busy, done, fault_lock}), 0);
    reset = 1'b0;
    nb = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("held_trig_no_fire", nb, 0);
    trig = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
